// File: rtl/tx_mac_framer_pkg.sv
// Shared types and constants for the transmit MAC framer.
// Byte values, CRC-32 constants, field offsets, FSM state enum.
package tx_mac_framer_pkg;

  localparam int GMII_DATA_W = 8;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  localparam int DEF_MIN_FRAME_BYTES = 60;
  localparam int DEF_IPG_BYTES       = 12;
  localparam int DEF_PREAMBLE_BYTES  = 7;

  localparam int SRC_MAC_OFS    = 6;
  localparam int ETHER_TYPE_OFS = 12;
  localparam int PAYLOAD_OFS    = 14;

  localparam int BYTE_CNT_W = 11;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IPG
  } tx_mac_state_t;

endpackage

// File: rtl/tx_mac_framer_if.sv
// Upstream byte stream into the TX MAC framer.
// master: byte source; slave: framer (drives tx_ready_o).
interface tx_mac_framer_if;
  import tx_mac_framer_pkg::*;

  logic [GMII_DATA_W-1:0] tx_data_i;
  logic                   tx_valid_i;
  logic                   tx_last_i;
  logic                   tx_ready_o;

  modport master (
    output tx_data_i, tx_valid_i, tx_last_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i, tx_last_i,
    output tx_ready_o
  );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational CRC-32 (reflected) update by one byte.
// crc_i: running CRC, data_i: byte, crc_o: updated CRC.
module eth_crc32_byte
  import tx_mac_framer_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/tx_mac_framer.sv
// TX MAC framer: preamble, SFD, data, zero pad, FCS, IPG.
// Ports: clk/rst, upstream stream (up), GMII byte + field flags.
module tx_mac_framer
  import tx_mac_framer_pkg::*;
#(
  parameter int IPG_BYTES       = DEF_IPG_BYTES,
  parameter int MIN_FRAME_BYTES = DEF_MIN_FRAME_BYTES,
  parameter int PREAMBLE_BYTES  = DEF_PREAMBLE_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  tx_mac_framer_if.slave         up,
  output logic [GMII_DATA_W-1:0] gmii_tx_data_o,
  output logic                   gmii_tx_en_o,
  output logic                   gmii_tx_er_o,
  output logic                   is_preamble_or_sfd_o,
  output logic                   is_dst_mac_o,
  output logic                   is_src_mac_o,
  output logic                   is_ether_type_o,
  output logic                   is_payload_or_crc_o
);

  tx_mac_state_t         state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [BYTE_CNT_W-1:0] bcnt, bcnt_n, bcnt_inc;
  logic [31:0]           crc, crc_n, crc_upd, fcs;
  logic [7:0]            crc_byte;

  logic [7:0] data_n;
  logic       en_n, er_n, pre_n, pay_n;
  logic       dst_n, src_n, typ_n;
  logic       by_idx;

  assign up.tx_ready_o = (state == ST_DATA);

  // Byte counter holds at its maximum rather than wrapping
  assign bcnt_inc = (&bcnt) ? bcnt : bcnt + 1'b1;
  assign fcs      = ~crc;
  assign crc_byte = (state == ST_DATA) ? up.tx_data_i : 8'h00;

  eth_crc32_byte u_crc (
    .crc_i  (crc),
    .data_i (crc_byte),
    .crc_o  (crc_upd)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    crc_n   = crc;
    data_n  = '0;
    en_n    = 1'b0;
    er_n    = 1'b0;
    pre_n   = 1'b0;
    pay_n   = 1'b0;
    by_idx  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (up.tx_valid_i) begin
          state_n = ST_PREAMBLE;
          cnt_n   = CNT_W'(1);
          bcnt_n  = '0;
          crc_n   = CRC32_INIT;
          data_n  = PREAMBLE_BYTE;
          en_n    = 1'b1;
          pre_n   = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        en_n  = 1'b1;
        pre_n = 1'b1;
        // SFD goes out while DATA already accepts byte 0
        if (cnt == CNT_W'(PREAMBLE_BYTES)) begin
          data_n  = SFD_BYTE;
          state_n = ST_DATA;
        end else begin
          data_n = PREAMBLE_BYTE;
          cnt_n  = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        en_n   = 1'b1;
        by_idx = 1'b1;
        cnt_n  = '0;
        if (up.tx_valid_i) begin
          data_n = up.tx_data_i;
          crc_n  = crc_upd;
          bcnt_n = bcnt_inc;
          if (up.tx_last_i) begin
            state_n = (bcnt_inc < BYTE_CNT_W'(MIN_FRAME_BYTES))
                    ? ST_PAD : ST_FCS;
          end
        end else begin
          er_n    = 1'b1;
          state_n = ST_IPG;
        end
      end
      ST_PAD: begin
        en_n   = 1'b1;
        by_idx = 1'b1;
        crc_n  = crc_upd;
        bcnt_n = bcnt_inc;
        if (bcnt_inc == BYTE_CNT_W'(MIN_FRAME_BYTES)) begin
          state_n = ST_FCS;
          cnt_n   = '0;
        end
      end
      ST_FCS: begin
        en_n   = 1'b1;
        pay_n  = 1'b1;
        data_n = fcs[8*cnt[1:0] +: 8];
        cnt_n  = cnt + 1'b1;
        if (cnt[1:0] == 2'd3) begin
          state_n = ST_IPG;
          cnt_n   = '0;
        end
      end
      ST_IPG: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_W'(IPG_BYTES - 1)) begin
          cnt_n = '0;
          if (up.tx_valid_i) begin
            state_n = ST_PREAMBLE;
            bcnt_n  = '0;
            crc_n   = CRC32_INIT;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    dst_n = 1'b0;
    src_n = 1'b0;
    typ_n = 1'b0;
    if (by_idx) begin
      dst_n = bcnt < BYTE_CNT_W'(SRC_MAC_OFS);
      src_n = (bcnt >= BYTE_CNT_W'(SRC_MAC_OFS))
            && (bcnt < BYTE_CNT_W'(ETHER_TYPE_OFS));
      typ_n = (bcnt >= BYTE_CNT_W'(ETHER_TYPE_OFS))
            && (bcnt < BYTE_CNT_W'(PAYLOAD_OFS));
      pay_n = bcnt >= BYTE_CNT_W'(PAYLOAD_OFS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      cnt                  <= '0;
      bcnt                 <= '0;
      crc                  <= CRC32_INIT;
      gmii_tx_data_o       <= '0;
      gmii_tx_en_o         <= 1'b0;
      gmii_tx_er_o         <= 1'b0;
      is_preamble_or_sfd_o <= 1'b0;
      is_dst_mac_o         <= 1'b0;
      is_src_mac_o         <= 1'b0;
      is_ether_type_o      <= 1'b0;
      is_payload_or_crc_o  <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      bcnt                 <= bcnt_n;
      crc                  <= crc_n;
      gmii_tx_data_o       <= data_n;
      gmii_tx_en_o         <= en_n;
      gmii_tx_er_o         <= er_n;
      is_preamble_or_sfd_o <= pre_n;
      is_dst_mac_o         <= dst_n;
      is_src_mac_o         <= src_n;
      is_ether_type_o      <= typ_n;
      is_payload_or_crc_o  <= pay_n;
    end
  end

endmodule

// File: tb/tb_tx_mac_framer.sv
// Self-checking bench for tx_mac_framer.
// Random frames checked against a frame-level reference model.
module tb_tx_mac_framer;

  typedef logic [7:0]  bq_t[$];
  typedef logic [12:0] eq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] gdata;
  logic gen, ger, fpre, fdst, fsrc, ftyp, fpay;

  logic [31:0] cv_crc, cv_out;
  logic [7:0]  cv_data;

  int n_cmp = 0;
  int n_bad = 0;
  int rd = 0;
  logic [14:0] cap[$];

  tx_mac_framer_if u_if ();

  tx_mac_framer u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .up                   (u_if),
    .gmii_tx_data_o       (gdata),
    .gmii_tx_en_o         (gen),
    .gmii_tx_er_o         (ger),
    .is_preamble_or_sfd_o (fpre),
    .is_dst_mac_o         (fdst),
    .is_src_mac_o         (fsrc),
    .is_ether_type_o      (ftyp),
    .is_payload_or_crc_o  (fpay)
  );

  eth_crc32_byte u_crc (
    .crc_i  (cv_crc),
    .data_i (cv_data),
    .crc_o  (cv_out)
  );

  always #4 clk = ~clk;

  always @(negedge clk)
    cap.push_back({gen, ger, fpre, fdst, fsrc, ftyp, fpay, gdata});

  // Bit-serial CRC-32 over the whole frame, LSB of each byte first
  function automatic logic [31:0] crc_model(bq_t f);
    logic [31:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      b = f[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  // Expected tx_en-high bytes: {pre,dst,src,type,pay,data}
  function automatic eq_t build(bq_t d);
    eq_t e;
    bq_t f;
    logic [31:0] c;
    int len;
    len = (d.size() < 60) ? 60 : d.size();
    for (int i = 0; i < len; i++)
      f.push_back((i < d.size()) ? d[i] : 8'h00);
    for (int i = 0; i < 7; i++) e.push_back({5'b10000, 8'h55});
    e.push_back({5'b10000, 8'hD5});
    for (int i = 0; i < len; i++)
      e.push_back({1'b0, i < 6, (i >= 6) && (i < 12),
                   (i >= 12) && (i < 14), i >= 14, f[i]});
    c = ~crc_model(f);
    for (int k = 0; k < 4; k++) e.push_back({5'b00001, c[8*k +: 8]});
    return e;
  endfunction

  function automatic bq_t rnd_frame(int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Next tx_en-high run from the capture, with preceding idle count
  task automatic grab(output eq_t run, output int gap,
                      output int er_cnt, output int er_pos);
    run = {};
    gap = 0;
    er_cnt = 0;
    er_pos = -1;
    while (rd < cap.size() && cap[rd][14] == 1'b0) begin
      gap++;
      rd++;
    end
    while (rd < cap.size() && cap[rd][14] == 1'b1) begin
      if (cap[rd][13]) begin
        er_cnt++;
        er_pos = run.size();
      end
      run.push_back(cap[rd][12:0]);
      rd++;
    end
  endtask

  // Upstream source; drop_at>=0 removes valid after that many bytes
  task automatic drive(bq_t d, int drop_at);
    int i = 0;
    int guard = 0;
    logic acc;
    u_if.tx_valid_i = 1'b1;
    u_if.tx_data_i  = d[0];
    u_if.tx_last_i  = (d.size() == 1);
    while (i < d.size()) begin
      if (guard++ > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drive_timeout got %0d want %0d bytes", i, d.size());
        break;
      end
      @(negedge clk);
      acc = u_if.tx_ready_o;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i == drop_at) begin
          u_if.tx_valid_i = 1'b0;
          u_if.tx_last_i  = 1'b0;
          break;
        end
        if (i < d.size()) begin
          u_if.tx_data_i = d[i];
          u_if.tx_last_i = (i == d.size() - 1);
        end else begin
          u_if.tx_valid_i = 1'b0;
          u_if.tx_last_i  = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset;
    u_if.tx_valid_i = 1'b1;
    u_if.tx_data_i  = 8'h5A;
    u_if.tx_last_i  = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({gen, ger, fpre, fdst, fsrc, ftyp, fpay, gdata} !== 15'h0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 0",
               {gen, ger, fpre, fdst, fsrc, ftyp, fpay, gdata});
    end
    n_cmp++;
    if (u_if.tx_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready got %b want 0", u_if.tx_ready_o);
    end
    u_if.tx_valid_i = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({gen, ger, gdata, u_if.tx_ready_o} !== 11'h0) begin
      n_bad++;
      $display("FAIL idle_outs got %h want 0",
               {gen, ger, gdata, u_if.tx_ready_o});
    end
  endtask

  task automatic test_crc_vector;
    string s;
    logic [31:0] c;
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < s.len(); i++) begin
      cv_crc  = c;
      cv_data = s[i];
      #1;
      c = cv_out;
    end
    n_cmp++;
    if (~c !== 32'hCBF43926) begin
      n_bad++;
      $display("FAIL crc_check got %h want cbf43926", ~c);
    end
  endtask

  task automatic test_one_byte;
    bq_t d;
    eq_t e, run;
    int gap, ec, ep;
    d.push_back(8'hAA);
    e = build(d);
    rd = cap.size();
    drive(d, -1);
    repeat (90) @(posedge clk);
    grab(run, gap, ec, ep);
    n_cmp++;
    if (run.size() != 72) begin
      n_bad++;
      $display("FAIL one_len got %0d want 72", run.size());
    end
    for (int i = 0; i < e.size() && i < run.size(); i++) begin
      n_cmp++;
      if (run[i] !== e[i]) begin
        n_bad++;
        $display("FAIL one_byte[%0d] got %h want %h", i, run[i], e[i]);
      end
    end
    n_cmp++;
    if (run.size() > 8 && run[8] !== {5'b01000, 8'hAA}) begin
      n_bad++;
      $display("FAIL one_dst got %h want 10aa", run[8]);
    end
    n_cmp++;
    if (ec != 0) begin
      n_bad++;
      $display("FAIL one_er got %0d want 0", ec);
    end
  endtask

  task automatic test_min64;
    bq_t d;
    eq_t e, run;
    int gap, ec, ep;
    d = rnd_frame(64);
    e = build(d);
    rd = cap.size();
    drive(d, -1);
    repeat (30) @(posedge clk);
    grab(run, gap, ec, ep);
    n_cmp++;
    if (run.size() != 76) begin
      n_bad++;
      $display("FAIL b64_len got %0d want 76", run.size());
    end
    for (int i = 0; i < e.size() && i < run.size(); i++) begin
      n_cmp++;
      if (run[i] !== e[i]) begin
        n_bad++;
        $display("FAIL b64_byte[%0d] got %h want %h", i, run[i], e[i]);
      end
    end
  endtask

  task automatic test_random;
    bq_t d;
    eq_t e, run;
    int gap, ec, ep;
    for (int f = 0; f < 5; f++) begin
      d = rnd_frame($urandom_range(1, 90));
      e = build(d);
      rd = cap.size();
      drive(d, -1);
      repeat (90) @(posedge clk);
      grab(run, gap, ec, ep);
      n_cmp++;
      if (run.size() != e.size()) begin
        n_bad++;
        $display("FAIL rnd%0d_len got %0d want %0d", f, run.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < run.size(); i++) begin
        n_cmp++;
        if (run[i] !== e[i]) begin
          n_bad++;
          $display("FAIL rnd%0d_byte[%0d] got %h want %h",
                   f, i, run[i], e[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    bq_t a, b;
    eq_t ea, eb, ra, rb;
    int gap, ec, ep;
    a = rnd_frame(10);
    b = rnd_frame(70);
    ea = build(a);
    eb = build(b);
    rd = cap.size();
    drive(a, -1);
    drive(b, -1);
    repeat (30) @(posedge clk);
    grab(ra, gap, ec, ep);
    grab(rb, gap, ec, ep);
    n_cmp++;
    if (gap != 12) begin
      n_bad++;
      $display("FAIL b2b_gap got %0d want 12", gap);
    end
    n_cmp++;
    if (ra.size() != ea.size() || rb.size() != eb.size()) begin
      n_bad++;
      $display("FAIL b2b_len got %0d/%0d want %0d/%0d",
               ra.size(), rb.size(), ea.size(), eb.size());
    end
    for (int i = 0; i < ea.size() && i < ra.size(); i++) begin
      n_cmp++;
      if (ra[i] !== ea[i]) begin
        n_bad++;
        $display("FAIL b2b_a[%0d] got %h want %h", i, ra[i], ea[i]);
      end
    end
    for (int i = 0; i < eb.size() && i < rb.size(); i++) begin
      n_cmp++;
      if (rb[i] !== eb[i]) begin
        n_bad++;
        $display("FAIL b2b_b[%0d] got %h want %h", i, rb[i], eb[i]);
      end
    end
  endtask

  task automatic test_underrun;
    bq_t a, b;
    eq_t ea, eb, ra, rb;
    int gap, ec, ep;
    a = rnd_frame(40);
    b = rnd_frame(61);
    ea = build(a);
    eb = build(b);
    rd = cap.size();
    drive(a, 20);
    repeat (2) @(posedge clk);
    #1;
    drive(b, -1);
    repeat (30) @(posedge clk);
    grab(ra, gap, ec, ep);
    n_cmp++;
    if (ra.size() != 29) begin
      n_bad++;
      $display("FAIL ur_len got %0d want 29", ra.size());
    end
    n_cmp++;
    if (ec != 1 || ep != 28) begin
      n_bad++;
      $display("FAIL ur_er got cnt %0d pos %0d want 1 28", ec, ep);
    end
    n_cmp++;
    if (ra.size() == 29 && ra[28][7:0] !== 8'h00) begin
      n_bad++;
      $display("FAIL ur_data got %h want 00", ra[28][7:0]);
    end
    for (int i = 0; i < 28 && i < ra.size(); i++) begin
      n_cmp++;
      if (ra[i] !== ea[i]) begin
        n_bad++;
        $display("FAIL ur_a[%0d] got %h want %h", i, ra[i], ea[i]);
      end
    end
    grab(rb, gap, ec, ep);
    n_cmp++;
    if (gap != 12) begin
      n_bad++;
      $display("FAIL ur_gap got %0d want 12", gap);
    end
    n_cmp++;
    if (rb.size() != eb.size()) begin
      n_bad++;
      $display("FAIL ur_b_len got %0d want %0d", rb.size(), eb.size());
    end
    for (int i = 0; i < eb.size() && i < rb.size(); i++) begin
      n_cmp++;
      if (rb[i] !== eb[i]) begin
        n_bad++;
        $display("FAIL ur_b[%0d] got %h want %h", i, rb[i], eb[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    bq_t d;
    eq_t e, run;
    int gap, ec, ep;
    @(posedge clk);
    #1;
    u_if.tx_valid_i = 1'b1;
    u_if.tx_last_i  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      u_if.tx_data_i = 8'($urandom);
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b1;
    u_if.tx_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({gen, ger, fpre, fdst, fsrc, ftyp, fpay, gdata} !== 15'h0
        || u_if.tx_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_outs got %h want 0",
               {gen, ger, fpre, fdst, fsrc, ftyp, fpay, gdata});
    end
    @(negedge clk);
    rst = 1'b0;
    d = rnd_frame(60);
    e = build(d);
    rd = cap.size();
    drive(d, -1);
    repeat (30) @(posedge clk);
    grab(run, gap, ec, ep);
    n_cmp++;
    if (run.size() != 72 || ec != 0) begin
      n_bad++;
      $display("FAIL rstmid_len got %0d er %0d want 72 er 0",
               run.size(), ec);
    end
    for (int i = 0; i < e.size() && i < run.size(); i++) begin
      n_cmp++;
      if (run[i] !== e[i]) begin
        n_bad++;
        $display("FAIL rstmid_byte[%0d] got %h want %h", i, run[i], e[i]);
      end
    end
  endtask

  initial begin
    u_if.tx_valid_i = 1'b0;
    u_if.tx_last_i  = 1'b0;
    u_if.tx_data_i  = 8'h00;
    cv_crc  = 32'h0;
    cv_data = 8'h0;
    test_reset();
    test_crc_vector();
    test_one_byte();
    test_min64();
    test_random();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
